// File: rtl/key_pkg.sv
// Shared types and constants for the key event controller.
// Holds the per-key FSM state encoding and the event field layout.
package key_pkg;

    typedef enum logic [3:0] {
        ST_DISARM = 4'b0001,
        ST_IDLE   = 4'b0010,
        ST_PRESS  = 4'b0100,
        ST_HELD   = 4'b1000
    } key_state_e;

    localparam int   EVT_LONG_W = 1;
    localparam logic EVT_SHORT  = 1'b0;
    localparam logic EVT_LONG   = 1'b1;

    function automatic int evt_key_w(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

endpackage

// File: rtl/key_press_fsm.sv
// Classifies one debounced, active-low key into short or long press events.
// evt_pulse is a single-cycle strobe in the cycle the classification is decided.
module key_press_fsm
    import key_pkg::*;
#(
    parameter int LONG_CNT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic tick,
    output logic evt_pulse,
    output logic evt_long
);

    localparam int HW = $clog2(LONG_CNT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CNT);

    key_state_e    state_r;
    key_state_e    state_nxt_s;
    logic [HW-1:0] hold_r;
    logic [HW-1:0] hold_nxt_s;

    // State and hold counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_DISARM;
            hold_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Next-state, hold counting and event strobes.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        evt_pulse   = 1'b0;
        evt_long    = EVT_SHORT;
        case (state_r)
            ST_DISARM: begin
                if (key_n) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DISARM;
                end
            end
            ST_IDLE: begin
                if (!key_n) begin
                    hold_nxt_s  = '0;
                    state_nxt_s = ST_PRESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESS: begin
                // A release seen in the same cycle as the final tick still counts as short.
                if (key_n) begin
                    evt_pulse   = 1'b1;
                    evt_long    = EVT_SHORT;
                    state_nxt_s = ST_IDLE;
                end else if (tick) begin
                    if (hold_r >= HOLD_LAST) begin
                        hold_nxt_s  = HOLD_MAX;
                        evt_pulse   = 1'b1;
                        evt_long    = EVT_LONG;
                        state_nxt_s = ST_HELD;
                    end else begin
                        hold_nxt_s  = hold_r + HW'(1);
                    end
                end else begin
                    state_nxt_s = ST_PRESS;
                end
            end
            ST_HELD: begin
                if (key_n) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            default: begin
                state_nxt_s = ST_DISARM;
                hold_nxt_s  = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event scheduler: per-key press classification, round-robin arbitration
// of pending events into a first-word fall-through FIFO, valid/ready output.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int TICK_DIV   = 50000,
    parameter int LONG_CNT   = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         key_n,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_KEYS)-1:0] evt_key,
    output logic                        evt_long,
    output logic                        fifo_full,
    output logic [7:0]                  drop_cnt
);

    localparam int KW = evt_key_w(NUM_KEYS);
    localparam int EW = KW + EVT_LONG_W;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [TW-1:0]       tick_cnt_r;
    logic                tick_s;
    logic [NUM_KEYS-1:0] evt_pulse_s;
    logic [NUM_KEYS-1:0] evt_long_s;
    logic [NUM_KEYS-1:0] pend_r;
    logic [NUM_KEYS-1:0] pend_nxt_s;
    logic [NUM_KEYS-1:0] plong_r;
    logic [NUM_KEYS-1:0] plong_nxt_s;
    logic [KW-1:0]       rr_ptr_r;
    logic                grant_s;
    logic [KW-1:0]       grant_idx_s;
    logic [3:0]          drop_inc_s;
    logic [8:0]          drop_sum_s;
    logic [EW-1:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic                push_s;
    logic                pop_s;
    logic                push_ok_s;

    assign tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));

    // Millisecond timebase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_press_fsm #(
            .LONG_CNT (LONG_CNT)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .key_n     (key_n[g]),
            .tick      (tick_s),
            .evt_pulse (evt_pulse_s[g]),
            .evt_long  (evt_long_s[g])
        );
    end

    assign evt_valid = (count_r != '0);
    assign fifo_full = (count_r == CW'(FIFO_DEPTH));
    assign pop_s     = evt_valid && evt_ready;
    assign push_ok_s = !fifo_full || pop_s;
    assign push_s    = grant_s;
    assign {evt_key, evt_long} = mem_r[rd_ptr_r];

    // Round-robin search over pending keys starting at the pointer.
    always_comb begin : arb_p
        int idx;
        idx         = 0;
        grant_s     = 1'b0;
        grant_idx_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            idx = int'(rr_ptr_r) + i;
            idx = (idx >= NUM_KEYS) ? (idx - NUM_KEYS) : idx;
            if (!grant_s && pend_r[KW'(idx)] && push_ok_s) begin
                grant_s     = 1'b1;
                grant_idx_s = KW'(idx);
            end else begin
                grant_s     = grant_s;
            end
        end
    end

    // Pending flag update and drop counting; a grant frees the slot for a same-cycle event.
    always_comb begin
        pend_nxt_s  = pend_r;
        plong_nxt_s = plong_r;
        drop_inc_s  = 4'd0;
        if (grant_s) begin
            pend_nxt_s[grant_idx_s] = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (evt_pulse_s[KW'(k)]) begin
                if (pend_r[KW'(k)] && !(grant_s && (grant_idx_s == KW'(k)))) begin
                    drop_inc_s = drop_inc_s + 4'd1;
                end else begin
                    pend_nxt_s[KW'(k)]  = 1'b1;
                    plong_nxt_s[KW'(k)] = evt_long_s[KW'(k)];
                end
            end else begin
                drop_inc_s = drop_inc_s;
            end
        end
        drop_sum_s = {1'b0, drop_cnt} + {5'd0, drop_inc_s};
    end

    // Pending flags, round-robin pointer and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r   <= '0;
            plong_r  <= '0;
            rr_ptr_r <= '0;
            drop_cnt <= 8'd0;
        end else begin
            pend_r   <= pend_nxt_s;
            plong_r  <= plong_nxt_s;
            drop_cnt <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
            if (grant_s) begin
                rr_ptr_r <= (grant_idx_s == KW'(NUM_KEYS - 1)) ? '0 : (grant_idx_s + KW'(1));
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                mem_r[d] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {grant_idx_s, plong_r[grant_idx_s]};
                wr_ptr_r <= (wr_ptr_r == AW'(FIFO_DEPTH - 1)) ? '0 : (wr_ptr_r + AW'(1));
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == AW'(FIFO_DEPTH - 1)) ? '0 : (rd_ptr_r + AW'(1));
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
